edge_capture: RTL and testbench
===============================

# edge_capture

Multi-channel edge capture block: the parametrised successor of the single-cycle edge detector used throughout the design. Each channel synchronises an asynchronous input, rejects glitches shorter than a programmable stable time, emits rise/fall pulses, and latches selected edges into a sticky pending bit that raises a shared interrupt. It sits between raw pins (buttons, external strobes, IRQ lines) and the register/interrupt logic.

## Interface
- P_width, 1, number of independent channels (≥1)
- P_sync, 2, synchroniser flops per channel (0 = input used directly, already synchronous)
- P_filter, 1, consecutive cycles a new value must persist before acceptance (≥1; 1 = no filtering)
- P_init, 1'b0 replicated, reset value of the filtered level per channel (P_width bits)

- I_clock  input  1  sole clock; all state updates on rising edge
- I_reset  input  1  synchronous, active-high reset
- I_signal  input  P_width  raw channel inputs, may be asynchronous
- I_mode  input  2*P_width  per-channel mode, channel n at bits [2n+1:2n]
- I_clear  input  P_width  write-1-to-clear for pending bits
- O_level  output  P_width  filtered, synchronised level
- O_rise  output  P_width  one-cycle pulse on accepted 0→1
- O_fall  output  P_width  one-cycle pulse on accepted 1→0
- O_event  output  P_width  one-cycle pulse on accepted edge matching mode
- O_pending  output  P_width  sticky captured events
- O_irq  output  1  OR of O_pending

## Operation
- Synchroniser: P_sync-flop shift chain per channel; output s.
- Filter: per-channel counter, width $clog2(P_filter) (min 1).
  - s == level: counter ← 0.
  - s != level and counter == P_filter-1: level ← s, counter ← 0, edge pulse generated.
  - s != level otherwise: counter ← counter+1.
  - Any return of s to level before acceptance discards progress.
- O_rise/O_fall registered: asserted in the cycle level changes, for exactly one cycle.
- Mode: 00 disabled, 01 rise, 10 fall, 11 both. O_event = (rise & mode[0]) | (fall & mode[1]), registered with O_rise/O_fall.
- Pending: set when corresponding event condition occurs; cleared by I_clear bit; set and clear same cycle → set wins (event not lost).
- O_irq combinational OR of O_pending.
- Mode changes apply to edges accepted on the next clock; disabling a channel does not clear its pending bit.
- Reset (any cycle, including mid-filter): sync flops and level ← P_init, counters ← 0, O_rise/O_fall/O_event/O_pending ← 0, hence O_irq = 0. No spurious edge after reset because sync chain matches level.

## Timing
- Latency input change → O_level/O_rise/O_fall/O_event: P_sync + P_filter cycles (edge sampling the change counts as cycle 1).
- O_pending set one cycle after O_event; O_irq same cycle as O_pending.
- I_clear effective on next edge; O_pending low the cycle after.
- Minimum accepted pulse width: P_filter cycles after synchronisation; shorter pulses produce no output.
- Maximum edge rate per channel: one accepted edge per P_filter cycles.

## Structure
- Package edge_pkg: mode typedef (enum logic[1:0] E_DISABLED, E_RISE, E_FALL, E_BOTH) and helper function for counter width.
- Sub-module edge_filter_chan: one channel's synchroniser, filter counter, level and rise/fall pulses; top instantiates P_width copies via generate and adds mode, event, pending and irq logic.

## Test plan
- P_sync=2, P_filter=4, mode=11: input 0→1 held → O_rise and O_event high exactly on cycle 6, O_pending high cycle 7, O_irq high cycle 7.
- Glitch: 3-cycle high pulse with P_filter=4 → O_level stays 0, no pulses, O_pending stays 0; 4-cycle pulse → one rise then one fall.
- Mode=01 on channel 0, mode=10 on channel 1, both toggled 0→1→0 → ch0 pending on rise only, ch1 on fall only; O_rise/O_fall pulse on both regardless.
- I_clear asserted in same cycle as new event → pending remains 1; I_clear alone next cycle → pending 0, O_irq 0.
- Reset asserted while filter counter at 3 of 4 with input high, P_init=0 → after release with input still high, rise occurs P_sync+P_filter cycles later, never earlier; P_init=1 with input high → no pulse at all.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared types for the edge capture block: per-channel capture mode and filter counter sizing.
package edge_pkg;

    typedef enum logic [1:0] {
        E_DISABLED = 2'b00,
        E_RISE     = 2'b01,
        E_FALL     = 2'b10,
        E_BOTH     = 2'b11
    } mode_e;

    // Counter must reach filter-1; a single-cycle filter still needs a 1-bit counter.
    function automatic int cnt_width(input int filter);
        return (filter > 1) ? $clog2(filter) : 1;
    endfunction

endpackage

// File: rtl/edge_capture_if.sv
// Channel-vector bundle between raw pins / register logic and edge_capture; no flow control.
interface edge_capture_if #(
    parameter int P_width = 1
);
    logic [P_width-1:0]   I_signal;
    logic [2*P_width-1:0] I_mode;
    logic [P_width-1:0]   I_clear;
    logic [P_width-1:0]   O_level;
    logic [P_width-1:0]   O_rise;
    logic [P_width-1:0]   O_fall;
    logic [P_width-1:0]   O_event;
    logic [P_width-1:0]   O_pending;
    logic                 O_irq;

    modport master (
        output I_signal, I_mode, I_clear,
        input  O_level, O_rise, O_fall, O_event, O_pending, O_irq
    );

    modport slave (
        input  I_signal, I_mode, I_clear,
        output O_level, O_rise, O_fall, O_event, O_pending, O_irq
    );
endinterface

// File: rtl/edge_filter_chan.sv
// One channel: synchroniser, glitch filter, level and registered rise/fall pulses.
// Latency P_sync + P_filter cycles from input change to level/pulse; never stalls.
module edge_filter_chan
    import edge_pkg::*;
#(
    parameter int   P_sync   = 2,
    parameter int   P_filter = 1,
    parameter logic P_init   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic signal,
    output logic level,
    output logic rise,
    output logic fall,
    output logic rise_nxt,
    output logic fall_nxt
);
    localparam int             CW       = cnt_width(P_filter);
    localparam logic [CW-1:0]  CNT_LAST = CW'(P_filter - 1);

    logic          s;
    logic [CW-1:0] cnt;
    logic          accept;

    generate
        if (P_sync == 0) begin : g_direct
            assign s = signal;
        end else begin : g_sync
            logic [P_sync-1:0] sync;
            // Chain resets to the same value as level so reset never yields an edge.
            always_ff @(posedge clk) begin
                if (rst) sync <= {P_sync{P_init}};
                else     sync <= (sync << 1) | P_sync'(signal);
            end
            assign s = sync[P_sync-1];
        end
    endgenerate

    assign accept   = (s != level) && (cnt == CNT_LAST);
    assign rise_nxt = accept & s;
    assign fall_nxt = accept & ~s;

    always_ff @(posedge clk) begin
        if (rst) begin
            level <= P_init;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= rise_nxt;
            fall <= fall_nxt;
            if (s == level) begin
                cnt <= '0;
            end else if (accept) begin
                level <= s;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/edge_capture.sv
// Multi-channel edge capture: filtered levels, edge pulses, mode-selected sticky pending bits, shared irq.
// Pulses P_sync + P_filter cycles after input change, pending one cycle later; no backpressure.
module edge_capture
    import edge_pkg::*;
#(
    parameter int                 P_width  = 1,
    parameter int                 P_sync   = 2,
    parameter int                 P_filter = 1,
    parameter logic [P_width-1:0] P_init   = '0
) (
    input  logic          I_clock,
    input  logic          I_reset,
    edge_capture_if.slave bus
);
    logic [P_width-1:0] level;
    logic [P_width-1:0] rise;
    logic [P_width-1:0] fall;
    logic [P_width-1:0] rise_nxt;
    logic [P_width-1:0] fall_nxt;
    logic [P_width-1:0] event_nxt;
    logic [P_width-1:0] event_q;
    logic [P_width-1:0] pending_q;

    generate
        for (genvar n = 0; n < P_width; n++) begin : g_chan
            mode_e mode;
            assign mode = mode_e'(bus.I_mode[2*n +: 2]);

            edge_filter_chan #(
                .P_sync   (P_sync),
                .P_filter (P_filter),
                .P_init   (P_init[n])
            ) u_chan (
                .clk      (I_clock),
                .rst      (I_reset),
                .signal   (bus.I_signal[n]),
                .level    (level[n]),
                .rise     (rise[n]),
                .fall     (fall[n]),
                .rise_nxt (rise_nxt[n]),
                .fall_nxt (fall_nxt[n])
            );

            // Mode is sampled on the accepting edge so the event lines up with rise/fall.
            assign event_nxt[n] = (rise_nxt[n] & (mode == E_RISE || mode == E_BOTH))
                                | (fall_nxt[n] & (mode == E_FALL || mode == E_BOTH));
        end
    endgenerate

    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            event_q   <= '0;
            pending_q <= '0;
        end else begin
            event_q   <= event_nxt;
            pending_q <= (pending_q & ~bus.I_clear) | event_q;
        end
    end

    assign bus.O_level   = level;
    assign bus.O_rise    = rise;
    assign bus.O_fall    = fall;
    assign bus.O_event   = event_q;
    assign bus.O_pending = pending_q;
    assign bus.O_irq     = |pending_q;

endmodule

// File: tb/tb_edge_capture.sv
// Scoreboard bench for edge_capture: a sample-window reference model queues expected outputs per edge.
module tb_edge_capture;

    localparam int             W    = 3;
    localparam int             SYNC = 2;
    localparam int             FILT = 4;
    localparam logic [W-1:0]   INIT = 3'b100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    edge_capture_if #(.P_width(W)) bus ();

    edge_capture #(
        .P_width  (W),
        .P_sync   (SYNC),
        .P_filter (FILT),
        .P_init   (INIT)
    ) dut (
        .I_clock (clk),
        .I_reset (rst),
        .bus     (bus)
    );

    typedef struct packed {
        logic [W-1:0] level;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic [W-1:0] ev;
        logic [W-1:0] pend;
        logic         irq;
    } obs_t;

    obs_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state
    logic [W-1:0]   m_lvl, m_pend, m_ev;
    bit             dly  [W][$];
    bit             hist [W][$];

    // Stimulus currently applied
    logic [W-1:0]   sig_v = '0;
    logic [W-1:0]   clr_v = '0;
    logic [2*W-1:0] md_v  = '1;

    task automatic model_step(input logic r, input logic [W-1:0] sig,
                              input logic [2*W-1:0] md, input logic [W-1:0] clr);
        obs_t         o;
        logic [W-1:0] init_v;
        logic [W-1:0] new_ev;
        logic [W-1:0] new_pend;
        bit           s, acc;
        o      = '0;
        init_v = INIT;
        new_ev = '0;
        if (r) begin
            m_lvl  = init_v;
            m_pend = '0;
            m_ev   = '0;
            for (int c = 0; c < W; c++) begin
                dly[c].delete();
                hist[c].delete();
                repeat (SYNC) dly[c].push_back(init_v[c]);
            end
            o.level = m_lvl;
        end else begin
            new_pend = (m_pend & ~clr) | m_ev;
            for (int c = 0; c < W; c++) begin
                dly[c].push_back(sig[c]);
                s = dly[c].pop_front();
                hist[c].push_back(s);
                if (hist[c].size() > FILT) void'(hist[c].pop_front());
                // Accept once the last FILT synchronised samples all disagree with the level.
                acc = (hist[c].size() == FILT);
                for (int k = 0; k < hist[c].size(); k++)
                    if (hist[c][k] == m_lvl[c]) acc = 1'b0;
                o.rise[c] = acc && s;
                o.fall[c] = acc && !s;
                new_ev[c] = (o.rise[c] && md[2*c]) || (o.fall[c] && md[2*c+1]);
                if (acc) m_lvl[c] = s;
            end
            m_ev    = new_ev;
            m_pend  = new_pend;
            o.level = m_lvl;
            o.ev    = m_ev;
            o.pend  = m_pend;
            o.irq   = |m_pend;
        end
        exp_q.push_back(o);
    endtask

    task automatic tick(input logic r);
        @(negedge clk);
        rst          = r;
        bus.I_signal = sig_v;
        bus.I_mode   = md_v;
        bus.I_clear  = clr_v;
        model_step(r, sig_v, md_v, clr_v);
    endtask

    task automatic tickn(input int n);
        repeat (n) tick(1'b0);
    endtask

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s t=%0t actual=%b required=%b", nm, $time, act, req);
        end
    endtask

    obs_t e_mon, a_mon;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            e_mon = exp_q.pop_front();
            a_mon = {bus.O_level, bus.O_rise, bus.O_fall, bus.O_event, bus.O_pending, bus.O_irq};
            chk("level",   a_mon.level, e_mon.level);
            chk("rise",    a_mon.rise,  e_mon.rise);
            chk("fall",    a_mon.fall,  e_mon.fall);
            chk("event",   a_mon.ev,    e_mon.ev);
            chk("pending", a_mon.pend,  e_mon.pend);
            chk("irq",     W'(a_mon.irq), W'(e_mon.irq));
        end
    end

    initial begin
        bus.I_signal = '0;
        bus.I_mode   = '1;
        bus.I_clear  = '0;

        // Reset; ch2 has init 1 and input held high so it must stay silent.
        sig_v = 3'b100;
        md_v  = 6'b111111;
        tick(1'b1);
        tick(1'b1);
        tickn(4);

        // ch0 rises and stays high: pulse on the 6th edge, pending/irq on the 7th.
        sig_v[0] = 1'b1;
        tickn(10);

        // Glitches on ch0 after returning low: 3-cycle pulse rejected, 4-cycle accepted.
        sig_v[0] = 1'b0;
        tickn(10);
        clr_v = '1;
        tick(1'b0);
        clr_v = '0;
        sig_v[0] = 1'b1; tickn(3);
        sig_v[0] = 1'b0; tickn(10);
        sig_v[0] = 1'b1; tickn(4);
        sig_v[0] = 1'b0; tickn(12);

        // ch0 rise-only, ch1 fall-only; pulses on both regardless of mode.
        clr_v = '1; tick(1'b0); clr_v = '0;
        md_v  = 6'b11_10_01;
        sig_v[1:0] = 2'b11; tickn(8);
        sig_v[1:0] = 2'b00; tickn(10);

        // Clear held across the new event: set wins, then a lone clear drops it.
        md_v  = 6'b111111;
        clr_v = '1;
        sig_v[0] = 1'b1; tickn(9);
        clr_v = '0; tickn(2);
        clr_v = '1; tickn(2);
        clr_v = '0;

        // Reset with the ch0 filter counter at 3 of 4 and input high.
        sig_v[0] = 1'b0; tickn(10);
        sig_v[0] = 1'b1; tickn(5);
        tick(1'b1);
        tickn(12);

        // Randomised phase.
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < W; c++)
                if ($urandom_range(0, 4) == 0) sig_v[c] = ~sig_v[c];
            if ($urandom_range(0, 49) == 0) md_v = (2*W)'($urandom);
            clr_v = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
            tick($urandom_range(0, 299) == 0);
        end
        clr_v = '0;
        tickn(3);

        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
